// File: rtl/add_accum_32_pkg.sv
// Shared definitions for the adder-result accumulator: FSM state encoding,
// default widths and the width of one {cout, sum} term.
package add_accum_pkg;

  localparam int ACC_W_DEFAULT = 40;
  localparam int CNT_W_DEFAULT = 8;
  localparam int TERM_W        = 33;

  // Plain vector encoding keeps the states compatible with older tooling
  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t ACCUM = 2'd1;
  localparam state_t DONE  = 2'd2;

endpackage

// File: rtl/add_accum_32_if.sv
// Handshake bundle between the adder datapath / controller and the accumulator.
// The accumulator attaches through the slave modport.
interface add_accum_32_if
  import add_accum_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) ();

  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      sum;
  logic             cout;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic             busy;

  modport master (
    output start, len, in_valid, sum, cout, out_ready,
    input  in_ready, out_valid, acc, ovf, busy
  );

  modport slave (
    input  start, len, in_valid, sum, cout, out_ready,
    output in_ready, out_valid, acc, ovf, busy
  );

endinterface

// File: rtl/add_accum_32.sv
// Accumulates a programmed number of 33-bit adder results into a wide total
// with a sticky carry-out flag; valid/ready handshakes on both sides.
module add_accum_32
  import add_accum_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  add_accum_32_if.slave bus
);

  localparam int PAD_W = ACC_W + 1 - TERM_W;

  state_t           state;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic [CNT_W-1:0] remaining;

  logic [ACC_W:0]   term_ext;
  logic [ACC_W:0]   add_res;
  logic             beat;

  // One extra bit on the add so the carry out of the accumulator is visible
  assign term_ext = {{PAD_W{1'b0}}, bus.cout, bus.sum};
  assign add_res  = {1'b0, acc_q} + term_ext;
  assign beat     = (state == ACCUM) && bus.in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            remaining <= bus.len;
            state     <= (bus.len != '0) ? ACCUM : DONE;
          end
        end
        ACCUM: begin
          if (beat) begin
            acc_q     <= add_res[ACC_W-1:0];
            ovf_q     <= ovf_q | add_res[ACC_W];
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs depend on registered state only
  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == ACCUM) || (state == DONE);
  assign bus.acc       = acc_q;
  assign bus.ovf       = ovf_q;

endmodule
